// File: rtl/lcd_bus_driver.sv
// Byte-level HD44780 write engine: one command/data byte per start/done handshake,
// generating RS/RW/EN/DATA pin timing followed by the controller's execution wait.
module lcd_bus_driver #(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned EN_CYC        = 16,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 80000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oBusy,
    output logic       oDone,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ENABLE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    // Each phase loads (length - 1) and ends on the edge that sees the counter at zero.
    localparam logic [19:0] SETUP_LD     = 20'(SETUP_CYC - 1);
    localparam logic [19:0] EN_LD        = 20'(EN_CYC - 1);
    localparam logic [19:0] HOLD_LD      = 20'(HOLD_CYC - 1);
    localparam logic [19:0] EXEC_LD      = 20'(EXEC_CYC - 1);
    localparam logic [19:0] LONG_EXEC_LD = 20'(LONG_EXEC_CYC - 1);

    state_t      state;
    logic [19:0] cnt;
    logic [7:0]  data_q;
    logic        long_q;
    logic        long_cmd;

    // Clear Display (0x01) and Return Home (0x02/0x03) need the long execution wait.
    assign long_cmd = !iRS && (iDATA[7:2] == 6'd0) && (iDATA[1:0] != 2'd0);

    // Write-only bus: the pins are always driven, the busy flag is never read back.
    assign LCD_DATA = data_q;
    assign LCD_RW   = 1'b0;

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data_q <= 8'h00;
            long_q <= 1'b0;
            LCD_EN <= 1'b0;
            LCD_RS <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                ST_IDLE: begin
                    oBusy <= 1'b0;
                    if (iStart) begin
                        data_q <= iDATA;
                        LCD_RS <= iRS;
                        long_q <= long_cmd;
                        cnt    <= SETUP_LD;
                        oBusy  <= 1'b1;
                        state  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        cnt    <= EN_LD;
                        LCD_EN <= 1'b1;
                        state  <= ST_ENABLE;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                ST_ENABLE: begin
                    if (cnt == '0) begin
                        cnt    <= HOLD_LD;
                        LCD_EN <= 1'b0;
                        state  <= ST_HOLD;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_q ? LONG_EXEC_LD : EXEC_LD;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                ST_WAIT: begin
                    // oBusy stays high through the oDone cycle; IDLE clears it.
                    if (cnt == '0) begin
                        oDone <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                default: begin
                    LCD_EN <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver: default, short-parameter and reduced-exec instances.
module tb_lcd_bus_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic [7:0] data;
    logic       rs, start, busy, done, lcd_rw, lcd_en, lcd_rs;
    wire  [7:0] lcd_data;

    // SETUP=EN=HOLD=EXEC=1 instance
    logic [7:0] s_data;
    logic       s_rs, s_start, s_busy, s_done, s_rw, s_en, s_rs_o;
    wire  [7:0] s_lcd_data;

    // Reduced exec times for the long-command decode table
    logic [7:0] m_data;
    logic       m_rs, m_start, m_busy, m_done, m_rw, m_en, m_rs_o;
    wire  [7:0] m_lcd_data;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         exp_done;
    } mvec_t;

    // EXEC=10, LONG=100: done at 4+16+4+EXEC
    mvec_t mtab [7] = '{
        '{1'b0, 8'h01, 124},
        '{1'b0, 8'h02, 124},
        '{1'b0, 8'h03, 124},
        '{1'b0, 8'h38, 34},
        '{1'b1, 8'h01, 34},
        '{1'b0, 8'h00, 34},
        '{1'b0, 8'h04, 34}
    };

    lcd_bus_driver dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iRS(rs), .iStart(start),
        .oBusy(busy), .oDone(done), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw),
        .LCD_EN(lcd_en), .LCD_RS(lcd_rs)
    );

    lcd_bus_driver #(
        .SETUP_CYC(1), .EN_CYC(1), .HOLD_CYC(1), .EXEC_CYC(1), .LONG_EXEC_CYC(1)
    ) dut_s (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(s_data), .iRS(s_rs), .iStart(s_start),
        .oBusy(s_busy), .oDone(s_done), .LCD_DATA(s_lcd_data), .LCD_RW(s_rw),
        .LCD_EN(s_en), .LCD_RS(s_rs_o)
    );

    lcd_bus_driver #(
        .EXEC_CYC(10), .LONG_EXEC_CYC(100)
    ) dut_m (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(m_data), .iRS(m_rs), .iStart(m_start),
        .oBusy(m_busy), .oDone(m_done), .LCD_DATA(m_lcd_data), .LCD_RW(m_rw),
        .LCD_EN(m_en), .LCD_RS(m_rs_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observe one transfer of the default instance from the accept cycle (k=0) up to
    // the oDone cycle; optionally fire ignored iStart pulses at A+10 and at the oDone edge.
    task automatic watch(input int budget, input bit inject, input logic [7:0] exp_data,
                         output int en_first, output int en_cnt, output int done_at,
                         output int done_cnt, output int busy_bad, output int pin_bad);
        en_first = -1; en_cnt = 0; done_at = -1; done_cnt = 0; busy_bad = 0; pin_bad = 0;
        for (int k = 0; k <= budget; k++) begin
            if (lcd_en) begin
                if (en_first < 0) en_first = k;
                en_cnt++;
            end
            if (!busy) busy_bad++;
            if (lcd_data !== exp_data || lcd_rw !== 1'b0) pin_bad++;
            if (done) begin
                done_at  = k;
                done_cnt = 1;
                break;
            end
            if (inject) begin
                if (k == 9)    begin start = 1'b1; data = 8'h55; end
                if (k == 10)   start = 1'b0;
                if (k == 2023) start = 1'b1;
            end
            step(1);
        end
    endtask

    initial begin
        int ef, ec, da, dc, bb, pb, ef1, done_seen;
        data = 8'h00; rs = 1'b0; start = 1'b0;
        s_data = 8'h00; s_rs = 1'b0; s_start = 1'b0;
        m_data = 8'h00; m_rs = 1'b0; m_start = 1'b0;

        // Reset values
        step(2);
        check("rst_en",   32'(lcd_en),   32'd0);
        check("rst_rs",   32'(lcd_rs),   32'd0);
        check("rst_rw",   32'(lcd_rw),   32'd0);
        check("rst_data", 32'(lcd_data), 32'h00);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        rst_n = 1'b1;
        step(2);

        // Reset mid-ENABLE: EN drops before the next edge, no oDone afterwards
        data = 8'hA5; rs = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(8);
        check("midrst_en_before", 32'(lcd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_en_async", 32'(lcd_en),   32'd0);
        check("midrst_data",     32'(lcd_data), 32'h00);
        check("midrst_rs",       32'(lcd_rs),   32'd0);
        check("midrst_busy",     32'(busy),     32'd0);
        step(3);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || lcd_en || busy) done_seen++;
            step(1);
        end
        check("midrst_quiet", 32'(done_seen), 32'd0);

        // Data write 0x41 with ignored iStart pulses at A+10 and at the oDone edge
        data = 8'h41; rs = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        watch(2100, 1'b1, 8'h41, ef, ec, da, dc, bb, pb);
        start = 1'b0;
        check("w41_en_first", 32'(ef), 32'd4);
        check("w41_en_cnt",   32'(ec), 32'd16);
        check("w41_done_at",  32'(da), 32'd2024);
        check("w41_done_cnt", 32'(dc), 32'd1);
        check("w41_busy",     32'(bb), 32'd0);
        check("w41_pins",     32'(pb), 32'd0);
        check("w41_rs",       32'(lcd_rs), 32'd1);
        step(1);
        check("w41_idle_busy", 32'(busy), 32'd0);
        check("w41_idle_done", 32'(done), 32'd0);
        step(3);
        check("w41_no_queue_en",  32'(lcd_en),   32'd0);
        check("w41_no_queue_bsy", 32'(busy),     32'd0);
        check("w41_data_kept",    32'(lcd_data), 32'h41);

        // Back-to-back with iStart held high
        data = 8'h48; rs = 1'b1; start = 1'b1;
        step(1);
        watch(2100, 1'b0, 8'h48, ef1, ec, da, dc, bb, pb);
        check("b2b1_en_first", 32'(ef1), 32'd4);
        check("b2b1_done_at",  32'(da),  32'd2024);
        data = 8'h49;
        step(1);
        start = 1'b0;
        check("b2b2_accept_data", 32'(lcd_data), 32'h49);
        check("b2b2_accept_busy", 32'(busy),     32'd1);
        watch(2100, 1'b0, 8'h49, ef, ec, da, dc, bb, pb);
        check("b2b_en_spacing", 32'(2025 + ef - ef1), 32'd2025);
        check("b2b2_done_at",   32'(da), 32'd2024);
        check("b2b2_en_cnt",    32'(ec), 32'd16);
        step(1);
        check("b2b2_idle_busy", 32'(busy), 32'd0);

        // Clear Display: long execution wait
        data = 8'h01; rs = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        watch(80100, 1'b0, 8'h01, ef, ec, da, dc, bb, pb);
        check("clr_done_at", 32'(da), 32'd80024);
        check("clr_en_cnt",  32'(ec), 32'd16);
        check("clr_busy",    32'(bb), 32'd0);
        check("clr_rs",      32'(lcd_rs), 32'd0);
        step(1);

        // Long-command decode on the reduced-exec instance
        for (int i = 0; i < 7; i++) begin
            m_data = mtab[i].d; m_rs = mtab[i].rs; m_start = 1'b1;
            step(1);
            m_start = 1'b0;
            da = -1;
            for (int k = 0; k <= 200; k++) begin
                if (m_done) begin
                    da = k;
                    break;
                end
                step(1);
            end
            check($sformatf("decode_%0d_rs%0d_%02h", i, mtab[i].rs, mtab[i].d),
                  32'(da), 32'(mtab[i].exp_done));
            check("decode_rw", 32'(m_rw), 32'd0);
            step(1);
        end

        // Short parameters: EN high only at A+1, oDone at A+4
        s_data = 8'h5A; s_rs = 1'b1; s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            check($sformatf("short_en_k%0d", k),   32'(s_en),   32'(k == 1));
            check($sformatf("short_done_k%0d", k), 32'(s_done), 32'(k == 4));
            check($sformatf("short_busy_k%0d", k), 32'(s_busy), 32'(k <= 4));
            check($sformatf("short_rw_k%0d", k),   32'(s_rw),   32'd0);
            step(1);
        end
        check("short_data", 32'(s_lcd_data), 32'h5A);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
